button_impulse_gen: RTL and testbench
=====================================

BUTTON_IMPULSE_GEN -- requirements
Module: button_impulse_gen

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, SHALL set the stable-input time before a debounced level change is accepted (10 ms at 50 MHz).
REQ-002 Parameter HOLD_CYCLES, default 25000000, SHALL set the press-and-hold time before auto-repeat starts (500 ms).
REQ-003 Parameter REPEAT_CYCLES, default 10000000, SHALL set the auto-repeat period (200 ms).
REQ-004 clk  input  1  SHALL be the single system clock; all state is clocked on its rising edge.
REQ-005 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 btn_next  input  1  SHALL be the raw, asynchronous, active-high "advance position" pushbutton.
REQ-007 btn_select  input  1  SHALL be the raw, asynchronous, active-high "confirm" pushbutton.
REQ-008 impulso  output  1  SHALL be a one-cycle advance pulse, intended for the position counter's increment input.
REQ-009 select  output  1  SHALL be the debounced confirm level, intended for the position counter's ready input.
REQ-010 select_pulse  output  1  SHALL be a one-cycle pulse on each debounced confirm press.

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 Debounce: the debounced level SHALL change only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free cycle SHALL clear the counter.
REQ-013 Debounce counter width SHALL be $clog2(DEBOUNCE_CYCLES+1); it SHALL saturate, never wrap.
REQ-014 The next-button FSM SHALL have states IDLE, HOLD and REPEAT.
REQ-015 IDLE -> HOLD on debounced rising edge of next; impulso=1 for exactly that cycle; hold counter cleared.
REQ-016 HOLD: hold counter increments each cycle; reaching HOLD_CYCLES-1 -> REPEAT with impulso=1 that cycle and repeat counter cleared.
REQ-017 REPEAT: repeat counter increments; reaching REPEAT_CYCLES-1 -> impulso=1 for one cycle and counter cleared (wrap to 0).
REQ-018 HOLD or REPEAT -> IDLE on the first cycle the debounced next level is 0; no impulso that cycle.
REQ-019 impulso SHALL never be high two consecutive cycles for any parameter values >= 2.
REQ-020 select SHALL equal the debounced confirm level; select_pulse SHALL be 1 for one cycle on its rising edge only.
REQ-021 Priority: while debounced select is 1, impulso SHALL be forced 0 and the next FSM held in IDLE (counters cleared).
REQ-022 Simultaneous debounced rising edges of both buttons in the same cycle: select_pulse=1, impulso=0, next FSM stays IDLE.
REQ-023 Release of select while next is still held SHALL NOT generate impulso; a fresh next press (debounced 0 then 1) is required.
REQ-024 Latency raw press -> impulso SHALL be 2 (sync) + DEBOUNCE_CYCLES + 1 cycles, fixed.

Reset
REQ-025 On reset_n=0, asynchronously: impulso=0, select=0, select_pulse=0, debounced levels=0, all counters=0, FSM=IDLE, synchronizer flops=0.
REQ-026 Reset asserted mid-hold or mid-repeat SHALL abort without emitting impulso; after release, a button already held SHALL be treated as a new press once debounced.

Structure
REQ-027 The FSM state enum (IDLE, HOLD, REPEAT) and default timing constants SHALL live in a shared package, vga_ctrl_pkg.
REQ-028 Synchronizer plus debounce SHALL be one sub-module, btn_debounce, instantiated once per button.
REQ-029 Timer comparisons SHALL use parameters only; no constants hard-coded in the FSM.

Verification (bench parameters DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3)
REQ-030 Clean press: btn_next 0->1 held 8 cycles then released -> exactly one impulso, 7 cycles after the input edge; select_pulse stays 0.
REQ-031 Bounce: btn_next toggles every 2 cycles for 12 cycles, then stays 1 -> no impulso during bouncing; one impulso 7 cycles after the final edge.
REQ-032 Auto-repeat: btn_next held 40 cycles -> impulso at press+7, then at press+17, then every 3 cycles until release; 9 pulses total; none after release.
REQ-033 Simultaneous: both buttons rise together -> select_pulse once, select=1, zero impulso; release select with next held -> still zero impulso.
REQ-034 Reset mid-repeat: reset_n low for 3 cycles during REPEAT -> all outputs 0 immediately; after release with next held -> new impulso 7 cycles after reset_n rises.
REQ-035 Chaining: drive the position counter from impulso with next held -> position wraps 9->0 and never skips a value.

Source files
------------

// File: rtl/vga_ctrl_pkg.sv
// Shared types and default timing for the pushbutton front end.
// Defaults assume a 50 MHz system clock.
package vga_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } next_state_e;

    localparam int DEF_DEBOUNCE = 500000;
    localparam int DEF_HOLD     = 25000000;
    localparam int DEF_REPEAT   = 10000000;

endpackage

// File: rtl/button_impulse_gen_if.sv
// Raw button inputs and conditioned outputs of the button front end.
// master drives buttons, slave produces pulses and levels.
interface button_impulse_gen_if;

    logic btn_next;
    logic btn_select;
    logic impulso;
    logic select;
    logic select_pulse;

    modport master (
        output btn_next,
        output btn_select,
        input  impulso,
        input  select,
        input  select_pulse
    );

    modport slave (
        input  btn_next,
        input  btn_select,
        output impulso,
        output select,
        output select_pulse
    );

endinterface

// File: rtl/button_impulse_gen_debounce.sv
// Two-flop synchronizer followed by a saturating debounce counter.
// The level flips only after DEBOUNCE_CYCLES consecutive mismatches.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] MAXV = CW'(DEBOUNCE_CYCLES);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[0], btn};
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= sync[1];
                cnt   <= '0;
            end else if (cnt != MAXV) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_impulse_gen.sv
// Turns the next/select pushbuttons into advance pulses with
// press-and-hold auto-repeat, and a debounced confirm level/pulse.
module button_impulse_gen
    import vga_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
    parameter int HOLD_CYCLES     = DEF_HOLD,
    parameter int REPEAT_CYCLES   = DEF_REPEAT
) (
    input logic                clk,
    input logic                reset_n,
    button_impulse_gen_if.slave bus
);

    localparam int HW = $clog2(HOLD_CYCLES);
    localparam int RW = $clog2(REPEAT_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

    logic        next_lvl;
    logic        sel_lvl;
    logic        next_q;
    logic        sel_q;
    logic        imp_q;
    logic        imp_d;
    next_state_e state;
    next_state_e state_d;
    logic [HW-1:0] hcnt;
    logic [HW-1:0] hcnt_d;
    logic [RW-1:0] rcnt;
    logic [RW-1:0] rcnt_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (bus.btn_next),
        .level   (next_lvl)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sel (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (bus.btn_select),
        .level   (sel_lvl)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            hcnt   <= '0;
            rcnt   <= '0;
            imp_q  <= 1'b0;
            next_q <= 1'b0;
            sel_q  <= 1'b0;
        end else begin
            state  <= state_d;
            hcnt   <= hcnt_d;
            rcnt   <= rcnt_d;
            imp_q  <= imp_d;
            next_q <= next_lvl;
            sel_q  <= sel_lvl;
        end
    end

    // next_q keeps tracking under select, so a held next is no new edge
    always_comb begin
        state_d = state;
        hcnt_d  = hcnt;
        rcnt_d  = rcnt;
        imp_d   = 1'b0;
        if (sel_lvl) begin
            state_d = IDLE;
            hcnt_d  = '0;
            rcnt_d  = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    hcnt_d = '0;
                    rcnt_d = '0;
                    if (next_lvl && !next_q) begin
                        state_d = HOLD;
                        imp_d   = 1'b1;
                    end
                end
                HOLD: begin
                    if (!next_lvl) begin
                        state_d = IDLE;
                    end else if (hcnt == HOLD_LAST) begin
                        state_d = REPEAT;
                        imp_d   = 1'b1;
                        rcnt_d  = '0;
                    end else begin
                        hcnt_d = hcnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!next_lvl) begin
                        state_d = IDLE;
                    end else if (rcnt == REP_LAST) begin
                        imp_d  = 1'b1;
                        rcnt_d = '0;
                    end else begin
                        rcnt_d = rcnt + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.impulso      = imp_q & ~sel_lvl;
    assign bus.select       = sel_lvl;
    assign bus.select_pulse = sel_lvl & ~sel_q;

endmodule

// File: tb/tb_button_impulse_gen.sv
// Directed bench for button_impulse_gen with short timing parameters.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_button_impulse_gen;

    logic clk;
    logic reset_n;
    int   n_chk;
    int   n_fail;
    int   cyc;
    int   t0;
    int   dbl;
    int   pos;
    int   wraps;
    logic prev_imp;
    int   imp_q[$];
    int   sp_q[$];
    int   exp_rep[9];

    button_impulse_gen_if bus ();

    button_impulse_gen #(
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (10),
        .REPEAT_CYCLES   (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int off_at(input int idx);
        if (idx < imp_q.size())
            return imp_q[idx] - t0;
        return -1;
    endfunction

    function automatic int sp_at(input int idx);
        if (idx < sp_q.size())
            return sp_q[idx] - t0;
        return -1;
    endfunction

    task automatic sample();
        if (bus.impulso) begin
            imp_q.push_back(cyc);
            if (prev_imp)
                dbl++;
            if (pos == 9) begin
                pos = 0;
                wraps++;
            end else begin
                pos++;
            end
        end
        prev_imp = bus.impulso;
        if (bus.select_pulse)
            sp_q.push_back(cyc);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            sample();
        end
    endtask

    task automatic clr();
        imp_q.delete();
        sp_q.delete();
        t0 = cyc;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        cyc = 0;
        dbl = 0;
        pos = 0;
        wraps = 0;
        prev_imp = 1'b0;
        exp_rep = '{7, 17, 20, 23, 26, 29, 32, 35, 38};
        reset_n = 1'b0;
        bus.btn_next = 1'b0;
        bus.btn_select = 1'b0;
        #1;
        chk("rst_imp", int'(bus.impulso), 0);
        chk("rst_sel", int'(bus.select), 0);
        chk("rst_sp", int'(bus.select_pulse), 0);
        step(2);
        reset_n = 1'b1;
        step(3);

        // clean press, 8 cycles
        clr();
        bus.btn_next = 1'b1;
        step(8);
        bus.btn_next = 1'b0;
        step(20);
        chk("clean_cnt", imp_q.size(), 1);
        chk("clean_lat", off_at(0), 7);
        chk("clean_sp", sp_q.size(), 0);

        // bounce, then stable high
        clr();
        for (int i = 0; i < 6; i++) begin
            bus.btn_next = (i % 2 == 0);
            step(2);
        end
        chk("bounce_none", imp_q.size(), 0);
        clr();
        bus.btn_next = 1'b1;
        step(8);
        bus.btn_next = 1'b0;
        step(20);
        chk("bounce_cnt", imp_q.size(), 1);
        chk("bounce_lat", off_at(0), 7);

        // auto-repeat; debounced level stays high through press+40
        clr();
        bus.btn_next = 1'b1;
        step(34);
        bus.btn_next = 1'b0;
        step(20);
        chk("rep_total", imp_q.size(), 9);
        for (int i = 0; i < 9; i++)
            chk($sformatf("rep_off%0d", i), off_at(i), exp_rep[i]);

        // simultaneous press, then select released first
        clr();
        bus.btn_next = 1'b1;
        bus.btn_select = 1'b1;
        step(12);
        chk("sim_sel", int'(bus.select), 1);
        chk("sim_sp_cnt", sp_q.size(), 1);
        chk("sim_sp_lat", sp_at(0), 6);
        chk("sim_imp", imp_q.size(), 0);
        bus.btn_select = 1'b0;
        step(12);
        chk("sim_sel_off", int'(bus.select), 0);
        chk("sim_rel_imp", imp_q.size(), 0);
        bus.btn_next = 1'b0;
        step(12);
        chk("sim_end_imp", imp_q.size(), 0);

        // reset during REPEAT with next held
        clr();
        bus.btn_next = 1'b1;
        step(21);
        chk("rr_pre_cnt", imp_q.size(), 3);
        reset_n = 1'b0;
        #1;
        chk("rr_imp", int'(bus.impulso), 0);
        chk("rr_sel", int'(bus.select), 0);
        chk("rr_sp", int'(bus.select_pulse), 0);
        clr();
        step(3);
        chk("rr_hold_imp", imp_q.size(), 0);
        reset_n = 1'b1;
        clr();
        step(12);
        chk("rr_post_cnt", imp_q.size(), 1);
        chk("rr_post_lat", off_at(0), 7);
        bus.btn_next = 1'b0;
        step(20);

        // position counter chained to impulso, wraps 9 -> 0
        clr();
        pos = 0;
        wraps = 0;
        bus.btn_next = 1'b1;
        step(38);
        bus.btn_next = 1'b0;
        step(20);
        chk("chain_cnt", imp_q.size(), 11);
        chk("chain_pos", pos, 1);
        chk("chain_wrap", wraps, 1);

        chk("no_double", dbl, 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
